// File: rtl/tdpram_portb_arb_pkg.sv
// Shared constants for the port-B arbiter of the 64/32 dual-port RAM.
// Owner encoding, read latency and the packed request width helper.
package tdpram_portb_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_0    = 2'd1;
  localparam logic [1:0] OWN_1    = 2'd2;

  localparam int RD_LATENCY     = 1;
  localparam int DEF_ADDR_WIDTH = 13;

  // Packed request is {we, be[3:0], addr[AW:0], wdata[31:0]}.
  localparam int PB_REQ_W = 1 + 4 + (DEF_ADDR_WIDTH + 1) + 32;

  function automatic int pb_req_w(input int aw);
    return 1 + 4 + (aw + 1) + 32;
  endfunction

endpackage

// File: rtl/tdpram_rr_arb2.sv
// Two-way round-robin arbiter with grant lock; one-hot combinational grant.
// A locked owner keeps the grant only while its request stays asserted.
module tdpram_rr_arb2
  import tdpram_portb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  logic       prio_q, prio_d;
  logic [1:0] owner_q, owner_d;
  logic       owner_hold;
  logic [1:0] gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      owner_q <= OWN_NONE;
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_hold = ((owner_q == OWN_0) && req_i[0]) ||
                 ((owner_q == OWN_1) && req_i[1]);
    gnt = 2'b00;
    if (owner_hold) begin
      gnt = (owner_q == OWN_1) ? 2'b10 : 2'b01;
    end else begin
      case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    prio_d  = prio_q;
    owner_d = owner_q;
    // An owner whose request fell is released; the cycle arbitrates normally.
    if (!owner_hold) owner_d = OWN_NONE;
    if (|gnt) begin
      prio_d = ~gnt[1];
      if (|(lock_i & gnt)) owner_d = gnt[1] ? OWN_1 : OWN_0;
      else                 owner_d = OWN_NONE;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/tdpram_portb_arb.sv
// Arbiter sharing the 32-bit RAM port B between two requesters.
// Muxes the granted request onto the RAM and steers read data back to its owner.
module tdpram_portb_arb
  import tdpram_portb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [3:0]            be0,
  input  logic [3:0]            be1,
  input  logic [ADDR_WIDTH:0]   addr0,
  input  logic [ADDR_WIDTH:0]   addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  ram_we,
  output logic                  ram_rd,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int REQ_W = pb_req_w(ADDR_WIDTH);

  logic [1:0]       req_v;
  logic [1:0]       gnt;
  logic [REQ_W-1:0] req_vec [2];
  logic [REQ_W-1:0] sel;
  logic             sel_we;

  logic rv_q   [RD_LATENCY];
  logic rsel_q [RD_LATENCY];
  logic rv_d, rsel_d;
  logic rv_out, rsel_out;

  // Requests are masked during reset so nothing reaches the RAM.
  assign req_v = {req1, req0} & {2{rst_n}};

  tdpram_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_v),
    .lock_i ({lock1, lock0}),
    .gnt_o  (gnt)
  );

  assign req_vec[0] = {we0, be0, addr0, wdata0};
  assign req_vec[1] = {we1, be1, addr1, wdata1};

  always_comb begin
    sel = '0;
    if (gnt[1])      sel = req_vec[1];
    else if (gnt[0]) sel = req_vec[0];
  end

  assign sel_we    = sel[REQ_W-1];
  assign ack0      = gnt[0];
  assign ack1      = gnt[1];
  assign ram_we    = sel_we;
  assign ram_rd    = (|gnt) & ~sel_we;
  assign ram_be    = sel_we ? sel[REQ_W-2 -: 4] : 4'h0;
  assign ram_addr  = sel[32 +: ADDR_WIDTH+1];
  assign ram_wdata = sel[31:0];

  assign rv_d   = ram_rd;
  assign rsel_d = ram_rd ? gnt[1] : rsel_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        rv_q[i]   <= 1'b0;
        rsel_q[i] <= 1'b0;
      end
    end else begin
      rv_q[0]   <= rv_d;
      rsel_q[0] <= rsel_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rv_q[i]   <= rv_q[i-1];
        rsel_q[i] <= rsel_q[i-1];
      end
    end
  end

  assign rv_out   = rv_q[RD_LATENCY-1];
  assign rsel_out = rsel_q[RD_LATENCY-1];

  assign rvalid0 = rv_out & ~rsel_out;
  assign rvalid1 = rv_out &  rsel_out;
  assign rdata0  = rvalid0 ? ram_rdata : 32'h0;
  assign rdata1  = rvalid1 ? ram_rdata : 32'h0;

endmodule
